// File: rtl/uart_prg_pkg.sv
// uart_prg_pkg: shared definitions for the UART program loader.
//   state_t    - frame FSM states
//   HEADER_DEF - default frame start byte
//   WORD_BITS  - width of one {addr, data} word shifted into the port
package uart_prg_pkg;
  localparam logic [7:0] HEADER_DEF = 8'hA5;
  localparam int WORD_BITS = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_LEN,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_GET_CSUM
  } state_t;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with a 2-flop synchronizer and mid-bit sampling.
//   clk, reset  - system clock, async active-high reset
//   rx          - asynchronous serial line, idle high
//   byte_valid  - one-cycle strobe, one cycle after a good stop-bit sample
//   byte_data   - received byte, valid while byte_valid is high
//   frame_err   - one-cycle strobe when the stop bit is sampled low
module uart_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     r_state, w_state;
  logic          r_sync1, r_sync2, r_prev;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [2:0]    r_bit, w_bit;
  logic [7:0]    r_shift, w_shift;
  logic          w_valid, w_ferr;

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt + 1'b1;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_valid = 1'b0;
    w_ferr  = 1'b0;
    unique case (r_state)
      RX_IDLE: begin
        w_cnt = '0;
        // Only a true high-to-low transition starts a frame, so a line held
        // low after a bad stop bit cannot retrigger until it returns high.
        if (r_prev && !r_sync2) w_state = RX_START;
      end
      RX_START: if (r_cnt == HALF) begin
        w_cnt   = '0;
        w_bit   = '0;
        // A glitch shorter than half a bit is back high here and is dropped.
        w_state = r_sync2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (r_cnt == FULL) begin
        w_cnt   = '0;
        w_shift = {r_sync2, r_shift[7:1]};
        w_bit   = r_bit + 1'b1;
        if (r_bit == 3'd7) w_state = RX_STOP;
      end
      RX_STOP: if (r_cnt == FULL) begin
        w_cnt   = '0;
        w_valid = r_sync2;
        w_ferr  = !r_sync2;
        w_state = RX_IDLE;
      end
      default: w_state = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_prev     <= 1'b1;
      r_state    <= RX_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_sync1    <= rx;
      r_sync2    <= r_sync1;
      r_prev     <= r_sync2;
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_bit      <= w_bit;
      byte_valid <= w_valid;
      frame_err  <= w_ferr;
    end
  end

  always_ff @(posedge clk) begin
    r_shift <= w_shift;
  end

  assign byte_data = r_shift;
endmodule

// File: rtl/uart_prg_loader.sv
// uart_prg_loader: receives HEADER, LEN, LEN x (addr, data), CSUM over UART
// and shifts each {addr, data} word MSB first into the programming port.
//   clk, reset    - system clock, async active-high reset
//   rx            - UART line, 8N1, idle high
//   prg           - high while a frame is being loaded
//   prg_din       - serial word data, sampled by the port on prg_shift_clk rise
//   prg_shift_clk - shift clock, SHIFT_DIV cycles low then SHIFT_DIV high per bit
//   prg_latch     - one-cycle RAM write strobe after the 16th bit
//   done, error   - sticky frame status, cleared by the next HEADER
module uart_prg_loader
  import uart_prg_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 104,
  parameter int         SHIFT_DIV    = 2,
  parameter logic [7:0] HEADER       = HEADER_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic prg,
  output logic prg_din,
  output logic prg_shift_clk,
  output logic prg_latch,
  output logic done,
  output logic error
);
  localparam int DW = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam int BW = $clog2(WORD_BITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(SHIFT_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_BITS - 1);
  localparam bit THRU_OK = (32 * SHIFT_DIV + 2) < (10 * CLKS_PER_BIT);

  logic       w_bv, w_fe;
  logic [7:0] w_bd;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_valid(w_bv),
    .byte_data (w_bd),
    .frame_err (w_fe)
  );

  state_t     r_state, w_state;
  logic [7:0] r_cnt, w_cnt, r_sum, w_sum, r_addr, w_addr, r_csum, w_csum;
  logic       r_csum_got, w_csum_got;
  logic       w_prg, w_done, w_error, w_start, w_abort;

  logic                 r_sh_busy, r_sh_phase;
  logic [DW-1:0]        r_sh_div;
  logic [BW-1:0]        r_sh_bit;
  logic [WORD_BITS-1:0] r_sh_word;

  always_comb begin
    w_state    = r_state;
    w_prg      = prg;
    w_done     = done;
    w_error    = error;
    w_cnt      = r_cnt;
    w_sum      = r_sum;
    w_addr     = r_addr;
    w_csum     = r_csum;
    w_csum_got = r_csum_got;
    w_start    = 1'b0;
    w_abort    = 1'b0;
    // Overrun: a new addr/data byte while the previous word is still shifting.
    if (prg && w_fe)
      w_abort = 1'b1;
    else if (w_bv && r_sh_busy && (r_state == ST_GET_ADDR || r_state == ST_GET_DATA))
      w_abort = 1'b1;

    if (w_abort) begin
      w_state = ST_IDLE;
      w_prg   = 1'b0;
      w_error = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: if (w_bv && w_bd == HEADER) begin
          w_state = ST_GET_LEN;
          w_prg   = 1'b1;
          w_done  = 1'b0;
          w_error = 1'b0;
        end
        ST_GET_LEN: if (w_bv) begin
          w_cnt   = w_bd;
          w_sum   = w_bd;
          w_state = ST_GET_ADDR;
        end
        ST_GET_ADDR: if (w_bv) begin
          w_addr  = w_bd;
          w_sum   = r_sum + w_bd;
          w_state = ST_GET_DATA;
        end
        ST_GET_DATA: if (w_bv) begin
          w_start    = 1'b1;
          w_sum      = r_sum + w_bd;
          // LEN=0 wraps to 255 here, giving 256 pairs.
          w_cnt      = r_cnt - 1'b1;
          w_csum_got = 1'b0;
          w_state    = (r_cnt == 8'd1) ? ST_GET_CSUM : ST_GET_ADDR;
        end
        ST_GET_CSUM: begin
          if (w_bv && !r_csum_got) begin
            w_csum     = w_bd;
            w_csum_got = 1'b1;
          end
          if (r_csum_got && !r_sh_busy) begin
            w_state = ST_IDLE;
            w_prg   = 1'b0;
            w_done  = (r_csum == r_sum);
            w_error = (r_csum != r_sum);
          end
        end
        default: w_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_csum_got <= 1'b0;
      prg        <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_csum_got <= w_csum_got;
      prg        <= w_prg;
      done       <= w_done;
      error      <= w_error;
    end
  end

  always_ff @(posedge clk) begin
    r_sum  <= w_sum;
    r_addr <= w_addr;
    r_csum <= w_csum;
  end

  // Shifter: each bit is SHIFT_DIV cycles low then SHIFT_DIV high; the latch
  // cycle follows the last high phase, so clock and latch never overlap.
  // An abort kills the word outright so no latch lands after prg drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh_busy     <= 1'b0;
      r_sh_phase    <= 1'b0;
      r_sh_div      <= '0;
      r_sh_bit      <= '0;
      prg_din       <= 1'b0;
      prg_shift_clk <= 1'b0;
      prg_latch     <= 1'b0;
    end else if (w_abort) begin
      r_sh_busy     <= 1'b0;
      r_sh_phase    <= 1'b0;
      prg_shift_clk <= 1'b0;
      prg_latch     <= 1'b0;
    end else if (w_start) begin
      r_sh_busy  <= 1'b1;
      r_sh_phase <= 1'b0;
      r_sh_div   <= '0;
      r_sh_bit   <= '0;
      prg_din    <= r_addr[7];
    end else if (prg_latch) begin
      prg_latch <= 1'b0;
      r_sh_busy <= 1'b0;
    end else if (r_sh_busy) begin
      if (r_sh_div != DIV_LAST) begin
        r_sh_div <= r_sh_div + 1'b1;
      end else begin
        r_sh_div <= '0;
        if (!r_sh_phase) begin
          r_sh_phase    <= 1'b1;
          prg_shift_clk <= 1'b1;
        end else begin
          r_sh_phase    <= 1'b0;
          prg_shift_clk <= 1'b0;
          if (r_sh_bit == BIT_LAST) begin
            prg_latch <= 1'b1;
          end else begin
            r_sh_bit <= r_sh_bit + 1'b1;
            prg_din  <= r_sh_word[WORD_BITS-2];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_start)
      r_sh_word <= {r_addr, w_bd};
    else if (r_sh_busy && r_sh_phase && r_sh_div == DIV_LAST && r_sh_bit != BIT_LAST)
      r_sh_word <= {r_sh_word[WORD_BITS-2:0], 1'b0};
  end

  always @(posedge clk) begin
    if (!reset)
      assert (THRU_OK) else $error("uart_prg_loader: word shift time exceeds one UART byte time");
  end
endmodule

// File: doc/uart_prg_loader.md
# uart_prg_loader

Serial program loader that sits directly upstream of the SoC's 16-bit shift-in programming port. It receives a framed image over an 8N1 UART line and asserts `prg` to hold the core in program mode. For every (address, data) pair it shifts a 16-bit word `{addr, data}` into the programming port, then pulses the latch that writes it into RAM. On completion it checks a checksum, releases `prg`, and reports `done` or `error`.

## Interface
- `CLKS_PER_BIT`, 104: clk cycles per UART bit. Must be ≥ 8.
- `SHIFT_DIV`, 2: clk cycles per half-period of `prg_shift_clk`. Must be ≥ 1.
- `HEADER`, 8'hA5: frame start byte.

Ports:
- `clk`  in  1: single system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `rx`  in  1: UART receive line, idle high, asynchronous to `clk`.
- `prg`  out  1: high while a frame is being loaded; stalls the core and muxes RAM to the port.
- `prg_din`  out  1: serial data, MSB first (`addr[7]` first, `data[0]` last).
- `prg_shift_clk`  out  1: shift clock; the port samples `prg_din` on its rising edge.
- `prg_latch`  out  1: latch/write strobe for the assembled word.
- `done`  out  1: sticky, set by a good frame; cleared by the next `HEADER` or by reset.
- `error`  out  1: sticky, set by a bad frame; cleared by the next `HEADER` or by reset.

## Operation
- RX path: 2-flop synchronizer on `rx`.
  - A falling edge starts a frame; the start bit is re-checked at `CLKS_PER_BIT/2`.
  - Data bits are sampled LSB first at mid-bit.
  - A stop bit sampled as 0 is a framing error.
  - Each good byte produces a one-cycle `byte_valid`.
- Frame format: `HEADER`, `LEN`, then `LEN` pairs (addr, data), then `CSUM`.
  - `LEN`=0 means 256 pairs.
  - `CSUM` = 8-bit sum, mod 256, of `LEN` and every addr and data byte.
- FSM states: IDLE, GET_LEN, GET_ADDR, GET_DATA, GET_CSUM.
  - IDLE: ignore every byte except `HEADER`. On `HEADER`, set `prg`=1, clear `done`/`error`, go to GET_LEN.
  - GET_LEN: store the count, seed the running sum, go to GET_ADDR.
  - GET_ADDR: store the address, go to GET_DATA.
  - GET_DATA: start the shifter with `{addr,data}` and decrement the count. Go to GET_CSUM if the count reaches 0, else to GET_ADDR.
  - GET_CSUM: wait for the shifter to go idle, then compare. Match sets `done`=1; mismatch sets `error`=1. Then `prg`=0, go to IDLE.
- Shifter, per word:
  - For each of 16 bits: drive `prg_din`, wait `SHIFT_DIV` cycles with `prg_shift_clk` low, then `SHIFT_DIV` cycles with it high.
  - After bit 16: `prg_latch` high for exactly 1 clk. This single cycle is the RAM write.
  - `prg_shift_clk` and `prg_latch` are never high together.
- Errors (all abort to IDLE with `error`=1 and `prg`=0):
  - framing error on any byte while `prg`=1;
  - overrun: a `byte_valid` in GET_ADDR or GET_DATA while the shifter is busy.
- No rollback: words already latched stay written after an error.
- A `HEADER` byte inside a frame is ordinary data.
- Framing errors in IDLE are silently dropped.

## Timing
- Reset values: all outputs 0; FSM in IDLE; shifter idle.
  - Reset mid-shift drops `prg_shift_clk` and `prg_latch` immediately and asynchronously.
  - No partial latch pulse is ever produced.
- `prg` rises the cycle after the `HEADER` `byte_valid`.
- `prg` falls the cycle after the CSUM compare; `done`/`error` rise in that same cycle.
- `byte_valid` asserts 1 cycle after the stop-bit mid-sample.
- Shifter latency, from the GET_DATA `byte_valid` to the end of the latch pulse: 1 + 32·`SHIFT_DIV` + 1 cycles.
- Every output is a registered flop; no combinational path from `rx`.
- Throughput constraint: 32·`SHIFT_DIV` + 2 < 10·`CLKS_PER_BIT`. Violating it causes overrun at full line rate; a simulation assertion checks it.

## Structure
- Package `uart_prg_pkg`: FSM state enum; `HEADER` default; `WORD_BITS`=16.
- Sub-module `uart_rx`: synchronizer, bit timer, byte assembly.
  - Outputs: `byte_valid`, `byte_data[7:0]`, `frame_err`.
  - Parameter: `CLKS_PER_BIT`.
- Top level holds the frame FSM, count, running sum, and the 16-bit shifter with its divider.

## Test plan
- Good frame A5 02 10 3C 11 7E CSUM=DD:
  - two words shifted, 0x103C then 0x117E, MSB first;
  - two 1-cycle latches;
  - `prg` high throughout, then `done`=1, `error`=0.
- Same frame with CSUM=DC: both words written, `error`=1, `done`=0, `prg` drops.
- Frame error on 3rd byte (stop bit forced 0): abort, `error`=1, `prg`=0, no latch pulse.
- Noise before start: stray bytes 00, FF, then a 0.3-bit glitch on `rx` in IDLE. Requires no `prg` and no `byte_valid`; the following A5 frame loads normally.
- `reset` asserted mid-word: all outputs 0 within the same cycle (async). Next frame after release loads correctly.
- `LEN`=00 with 256 pairs at full line rate, `CLKS_PER_BIT`=8, `SHIFT_DIV`=1:
  - 256 latches, no overrun;
  - addr 0xFF followed by wrap behaves normally;
  - `done`=1.
